// File: rtl/mcu_irq_ctrl_if.sv
// mcu_irq_ctrl_if: internal register bus between the FSMC bridge (master) and a register slave.
//   rdaddr  16  read word address
//   wraddr  16  write word address
//   be       2  byte enables; be[0] = bits 7:0, be[1] = bits 15:8
//   write    1  single-cycle write strobe qualifying wraddr/wrdata/be
//   wrdata  16  write data
//   rddata  16  registered read data, returned by the slave
interface mcu_irq_ctrl_if;
    logic [15:0] rdaddr;
    logic [15:0] wraddr;
    logic [1:0]  be;
    logic        write;
    logic [15:0] wrdata;
    logic [15:0] rddata;

    modport master (
        output rdaddr,
        output wraddr,
        output be,
        output write,
        output wrdata,
        input  rddata
    );

    modport slave (
        input  rdaddr,
        input  wraddr,
        input  be,
        input  write,
        input  wrdata,
        output rddata
    );
endinterface

// File: rtl/mcu_irq_ctrl.sv
// mcu_irq_ctrl: interrupt controller driving the MCU's active-low nirq line.
// Latches rising edges on src as pending bits. Exposes the PEND/MASK/STAT/VEC/CTRL registers on
// the register bus. Sequences nirq so that every interrupt still unserviced after an acknowledge
// produces a fresh falling edge.
//   clk   in         system clock
//   aclr  in         asynchronous reset, active-high
//   bus   slave      register bus (rdaddr, wraddr, be, write, wrdata in; rddata out)
//   src   in  N_SRC  event inputs, synchronous to clk; rising edge = event
//   nirq  out        interrupt request to the MCU, active-low, registered
module mcu_irq_ctrl #(
    parameter int unsigned N_SRC = 16,
    parameter logic [15:0] BASE  = 16'h0040,
    parameter int unsigned GAP   = 8
) (
    input  logic             clk,
    input  logic             aclr,
    mcu_irq_ctrl_if.slave    bus,
    input  logic [N_SRC-1:0] src,
    output logic             nirq
);

    // GAP state lasts GAP-1 cycles; the following IDLE cycle makes nirq high for exactly GAP.
    localparam int unsigned CW = (GAP > 2) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic             gen_q, gen_d;
    logic [15:0]      rddata_q, rddata_d;
    logic             nirq_q, nirq_d;

    logic [N_SRC-1:0] ev;
    logic [N_SRC-1:0] stat;
    logic [3:0]       vec_idx;
    logic [15:0]      vec;
    logic [15:0]      wr_off, rd_off;
    logic [15:0]      be_mask, wr_bits;
    logic             wr_pend, wr_mask, wr_ctrl;
    logic             ack;

    // Offsets wrap modulo 2^16, so one compare covers both ends of the window.
    assign wr_off  = bus.wraddr - BASE;
    assign rd_off  = bus.rdaddr - BASE;
    assign be_mask = {{8{bus.be[1]}}, {8{bus.be[0]}}};
    assign wr_bits = bus.wrdata & be_mask;

    assign wr_pend = bus.write && (wr_off == 16'd0);
    assign wr_mask = bus.write && (wr_off == 16'd1);
    assign wr_ctrl = bus.write && (wr_off == 16'd4);
    assign ack     = wr_pend && (|wr_bits[N_SRC-1:0]);

    assign ev   = src & ~src_q;
    assign stat = pend_q & mask_q;

    always_comb begin
        vec_idx = 4'd0;
        // Descending scan so the lowest set bit wins.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (stat[i]) begin
                vec_idx = 4'(i);
            end
        end
        vec = {|stat, 11'd0, vec_idx};
    end

    // Register next-state; a coincident event beats a W1C on the same bit.
    always_comb begin
        pend_d = pend_q;
        mask_d = mask_q;
        gen_d  = gen_q;
        if (wr_pend) begin
            pend_d = pend_q & ~wr_bits[N_SRC-1:0];
        end
        pend_d = pend_d | ev;
        if (wr_mask) begin
            mask_d = (mask_q & ~be_mask[N_SRC-1:0]) | wr_bits[N_SRC-1:0];
        end
        if (wr_ctrl && bus.be[0]) begin
            gen_d = bus.wrdata[0];
        end
    end

    // Read mux samples current register values, so a read coincident with an update is old data.
    always_comb begin
        rddata_d = 16'd0;
        case (rd_off)
            16'd0:   rddata_d = 16'(pend_q);
            16'd1:   rddata_d = 16'(mask_q);
            16'd2:   rddata_d = 16'(stat);
            16'd3:   rddata_d = vec;
            16'd4:   rddata_d = {15'd0, gen_q};
            default: rddata_d = 16'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (gen_q && (|stat)) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (ack || !gen_q || !(|stat)) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == CW'(GAP - 2)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        nirq_d = (state_d != StActive);
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            src_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            gen_q    <= 1'b0;
            rddata_q <= 16'd0;
            nirq_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            src_q    <= src;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            gen_q    <= gen_d;
            rddata_q <= rddata_d;
            nirq_q   <= nirq_d;
        end
    end

    assign bus.rddata = rddata_q;
    assign nirq       = nirq_q;

endmodule

// File: tb/tb_mcu_irq_ctrl.sv
// tb_mcu_irq_ctrl: self-checking bench for mcu_irq_ctrl.
// A register-access vector table followed by hand-written interrupt sequences.
module tb_mcu_irq_ctrl;
    localparam int unsigned N_SRC = 16;
    localparam logic [15:0] BASE  = 16'h0040;
    localparam int unsigned GAP   = 8;

    localparam logic [15:0] A_PEND = BASE;
    localparam logic [15:0] A_MASK = BASE + 16'd1;
    localparam logic [15:0] A_STAT = BASE + 16'd2;
    localparam logic [15:0] A_VEC  = BASE + 16'd3;
    localparam logic [15:0] A_CTRL = BASE + 16'd4;
    localparam logic [15:0] A_OUT  = BASE + 16'd5;

    logic             clk = 1'b0;
    logic             aclr;
    logic [N_SRC-1:0] src;
    logic             nirq;

    mcu_irq_ctrl_if bus ();

    mcu_irq_ctrl #(
        .N_SRC (N_SRC),
        .BASE  (BASE),
        .GAP   (GAP)
    ) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus),
        .src  (src),
        .nirq (nirq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    typedef struct {
        string       name;
        logic [15:0] wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic [15:0] ra;
        logic [15:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] be);
        bus.wraddr = addr;
        bus.wrdata = data;
        bus.be     = be;
        bus.write  = 1'b1;
        tick();
        bus.write  = 1'b0;
    endtask

    // Expected value is queued at issue and popped when rddata becomes valid.
    task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string name);
        exp_t e;
        bus.rdaddr = addr;
        sb.push_back('{name: name, val: exp});
        tick();
        e = sb.pop_front();
        check(e.name, bus.rddata, e.val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int lows;

        vecs[0] = '{"mask_be_lo",   A_MASK, 16'hFFFF, 2'b01, A_MASK, 16'h00FF};
        vecs[1] = '{"mask_be_hi",   A_MASK, 16'hAB00, 2'b10, A_MASK, 16'hABFF};
        vecs[2] = '{"mask_be_none", A_MASK, 16'h1234, 2'b00, A_MASK, 16'hABFF};
        vecs[3] = '{"wr_out_range", A_OUT,  16'hFFFF, 2'b11, A_MASK, 16'hABFF};
        vecs[4] = '{"rd_out_range", A_OUT,  16'hFFFF, 2'b11, A_OUT,  16'h0000};
        vecs[5] = '{"wr_below",     BASE - 16'd1, 16'h0000, 2'b11, A_MASK, 16'hABFF};
        vecs[6] = '{"ctrl_bit0",    A_CTRL, 16'hFFFE, 2'b11, A_CTRL, 16'h0000};
        vecs[7] = '{"ctrl_be_hi",   A_CTRL, 16'h0001, 2'b10, A_CTRL, 16'h0000};
        vecs[8] = '{"stat_zero",    A_MASK, 16'h0000, 2'b11, A_STAT, 16'h0000};
        vecs[9] = '{"pend_zero",    A_CTRL, 16'h0000, 2'b01, A_PEND, 16'h0000};

        aclr       = 1'b1;
        src        = '0;
        bus.rdaddr = 16'h0000;
        bus.wraddr = 16'h0000;
        bus.wrdata = 16'h0000;
        bus.be     = 2'b00;
        bus.write  = 1'b0;
        repeat (2) tick();
        check("reset_nirq", 16'(nirq), 16'h0001);
        check("reset_rddata", bus.rddata, 16'h0000);
        aclr = 1'b0;
        tick();

        foreach (vecs[i]) begin
            wr(vecs[i].wa, vecs[i].wd, vecs[i].be);
            rd(vecs[i].ra, vecs[i].exp, vecs[i].name);
        end

        // Event to nirq latency, plus read returning pre-update PEND.
        wr(A_MASK, 16'h0001, 2'b11);
        wr(A_CTRL, 16'h0001, 2'b01);
        src        = 16'h0001;
        bus.rdaddr = A_PEND;
        tick();
        check("lat_nirq_t1", 16'(nirq), 16'h0001);
        check("lat_pend_preupd", bus.rddata, 16'h0000);
        tick();
        check("lat_nirq_t2", 16'(nirq), 16'h0000);
        check("lat_pend_t2", bus.rddata, 16'h0001);
        rd(A_VEC, 16'h8000, "lat_vec");

        // Asynchronous reset while nirq is active.
        #2 aclr = 1'b1;
        #1;
        check("arst_nirq", 16'(nirq), 16'h0001);
        check("arst_rddata", bus.rddata, 16'h0000);
        @(posedge clk);
        #1 aclr = 1'b0;
        rd(A_PEND, 16'h0000, "arst_pend");
        rd(A_MASK, 16'h0000, "arst_mask");
        rd(A_CTRL, 16'h0000, "arst_ctrl");
        // src[0] was high through reset, so one event latched on the first clock.
        rd(A_PEND, 16'h0001, "arst_src_high_event");
        check("arst_nirq_idle", 16'(nirq), 16'h0001);
        src = '0;
        wr(A_PEND, 16'h0001, 2'b11);

        // Two pending sources, ack one -> gap of GAP cycles then a fresh assertion.
        wr(A_MASK, 16'hFFFF, 2'b11);
        wr(A_CTRL, 16'h0001, 2'b01);
        src = 16'h0028;
        tick();
        src = '0;
        tick();
        check("two_src_nirq", 16'(nirq), 16'h0000);
        rd(A_VEC, 16'h8003, "two_src_vec");
        wr(A_PEND, 16'h0008, 2'b11);
        hi = 0;
        while (nirq === 1'b1 && hi < int'(GAP) + 4) begin
            hi++;
            tick();
        end
        check("gap_len", 16'(hi), 16'(GAP));
        check("gap_reassert", 16'(nirq), 16'h0000);
        rd(A_VEC, 16'h8005, "ack1_vec");
        wr(A_PEND, 16'h0020, 2'b11);
        lows = 0;
        for (int i = 0; i < int'(GAP) + 5; i++) begin
            if (nirq !== 1'b1) lows++;
            tick();
        end
        check("ack_last_lows", 16'(lows), 16'h0000);
        rd(A_VEC, 16'h0000, "ack_last_vec");

        // Set and W1C on the same PEND bit in one cycle: set wins.
        src = 16'h0004;
        tick();
        src = '0;
        tick();
        src = 16'h0004;
        wr(A_PEND, 16'h0004, 2'b11);
        rd(A_PEND, 16'h0004, "set_beats_clr");
        src = '0;
        wr(A_PEND, 16'h0004, 2'b11);
        repeat (GAP + 2) tick();
        check("clr_nirq_idle", 16'(nirq), 16'h0001);
        rd(A_PEND, 16'h0000, "clr_pend");

        // Global enable gating.
        wr(A_CTRL, 16'h0000, 2'b01);
        src = 16'h0002;
        tick();
        src = '0;
        repeat (4) tick();
        check("gen0_nirq", 16'(nirq), 16'h0001);
        rd(A_STAT, 16'h0002, "gen0_stat");
        wr(A_CTRL, 16'h0001, 2'b01);
        check("gen1_nirq_wr", 16'(nirq), 16'h0001);
        tick();
        check("gen1_nirq_next", 16'(nirq), 16'h0000);
        rd(A_VEC, 16'h8001, "gen1_vec");

        // Unmasking an already pending bit in IDLE.
        wr(A_PEND, 16'h0002, 2'b11);
        repeat (GAP + 2) tick();
        wr(A_MASK, 16'h0000, 2'b11);
        src = 16'h0010;
        tick();
        src = '0;
        repeat (2) tick();
        check("masked_nirq", 16'(nirq), 16'h0001);
        wr(A_MASK, 16'h0010, 2'b01);
        check("unmask_nirq_wr", 16'(nirq), 16'h0001);
        tick();
        check("unmask_nirq_next", 16'(nirq), 16'h0000);
        rd(A_VEC, 16'h8004, "unmask_vec");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
